// File: rtl/mem_arbiter.sv
// Three-way round-robin arbiter (instruction read, data read, data write) onto one
// registered memory port, with an optional ack timeout that completes the stalled access.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_re,
    input  logic [XLEN/8-1:0]   instr_sel,
    input  logic [XLEN-1:0]     instr_addr,
    output logic                instr_ack,
    output logic [XLEN-1:0]     instr_data,
    input  logic                dr_re,
    input  logic [XLEN/8-1:0]   dr_sel,
    input  logic [XLEN-1:0]     dr_addr,
    output logic                dr_ack,
    output logic [XLEN-1:0]     dr_data,
    input  logic                dw_we,
    input  logic [XLEN/8-1:0]   dw_sel,
    input  logic [XLEN-1:0]     dw_addr,
    input  logic [XLEN-1:0]     dw_data,
    output logic                dw_ack,
    output logic                mem_re,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_sel,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_I  = 2'd1;
    localparam logic [1:0] BUSY_DR = 2'd2;
    localparam logic [1:0] BUSY_DW = 2'd3;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        last;   // BUSY_x code of the most recently completed requester
    logic [CW-1:0]     cnt;
    logic [1:0]        grant;
    logic [XLEN/8-1:0] g_sel;
    logic [XLEN-1:0]   g_addr;
    logic [XLEN-1:0]   g_wdata;
    logic              busy;
    logic              tmo_hit;
    logic              done;

    // Search starts with the requester after the last one served.
    always_comb begin
        grant = IDLE;
        case (last)
            BUSY_I: begin
                if (dr_re)         grant = BUSY_DR;
                else if (dw_we)    grant = BUSY_DW;
                else if (instr_re) grant = BUSY_I;
            end
            BUSY_DR: begin
                if (dw_we)         grant = BUSY_DW;
                else if (instr_re) grant = BUSY_I;
                else if (dr_re)    grant = BUSY_DR;
            end
            default: begin
                if (instr_re)      grant = BUSY_I;
                else if (dr_re)    grant = BUSY_DR;
                else if (dw_we)    grant = BUSY_DW;
            end
        endcase
    end

    always_comb begin
        g_sel   = dw_sel;
        g_addr  = dw_addr;
        g_wdata = dw_data;
        case (grant)
            BUSY_I: begin
                g_sel   = instr_sel;
                g_addr  = instr_addr;
                g_wdata = '0;
            end
            BUSY_DR: begin
                g_sel   = dr_sel;
                g_addr  = dr_addr;
                g_wdata = '0;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TMAX);
    assign done    = busy && (mem_ack || tmo_hit) && !reset;
    assign err     = busy && tmo_hit && !mem_ack && !reset;

    // A timed-out access completes with zero data; a real ack always wins.
    assign instr_ack  = done && (state == BUSY_I);
    assign dr_ack     = done && (state == BUSY_DR);
    assign dw_ack     = done && (state == BUSY_DW);
    assign instr_data = (instr_ack && mem_ack) ? mem_rdata : '0;
    assign dr_data    = (dr_ack && mem_ack) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= BUSY_DW;
            cnt       <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (!busy) begin
            if (grant != IDLE) begin
                state     <= grant;
                cnt       <= '0;
                mem_re    <= (grant != BUSY_DW);
                mem_we    <= (grant == BUSY_DW);
                mem_sel   <= g_sel;
                mem_addr  <= g_addr;
                mem_wdata <= g_wdata;
            end
        end else if (done) begin
            state  <= IDLE;
            last   <= state;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic, every cycle checked
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
    localparam int XLEN = 32;
    localparam int TO   = 4;

    logic clk = 1'b0;
    logic reset;
    logic instr_re, dr_re, dw_we, mem_ack;
    logic [3:0]  instr_sel, dr_sel, dw_sel;
    logic [31:0] instr_addr, dr_addr, dw_addr, dw_data, mem_rdata;
    logic instr_ack, dr_ack, dw_ack, mem_re, mem_we, err;
    logic [31:0] instr_data, dr_data, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr),
        .dr_ack(dr_ack), .dr_data(dr_data),
        .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_ack(dw_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: g = requester holding the port (-1 none, 0 I, 1 DR, 2 DW), last = last served.
    int g = -1, last = 2, waited = 0;
    logic e_re = 0, e_we = 0;
    logic [3:0]  e_sel = 0;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic o_iack, o_drack, o_dwack, o_err;
    logic [31:0] o_idata, o_drdata;
    int n_err = 0;
    logic prev_strobe = 0;
    logic [31:0] grants[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic fin;
        logic [2:0] rq;
        logic c_ia, c_da, c_wa, c_er;
        logic [31:0] c_id, c_dd;
        fin = 0; c_ia = 0; c_da = 0; c_wa = 0; c_er = 0; c_id = 0; c_dd = 0;
        if (!reset && g >= 0) begin
            fin  = mem_ack || (waited == TO);
            c_er = !mem_ack && (waited == TO);
            if (g == 0) begin c_ia = fin; c_id = mem_ack ? mem_rdata : 32'h0; end
            if (g == 1) begin c_da = fin; c_dd = mem_ack ? mem_rdata : 32'h0; end
            if (g == 2) c_wa = fin;
        end
        @(negedge clk);
        o_iack = instr_ack; o_drack = dr_ack; o_dwack = dw_ack; o_err = err;
        o_idata = instr_data; o_drdata = dr_data;
        if (err === 1'b1) n_err++;
        chk("instr_ack", {31'b0, instr_ack}, {31'b0, c_ia});
        chk("instr_data", instr_data, c_id);
        chk("dr_ack", {31'b0, dr_ack}, {31'b0, c_da});
        chk("dr_data", dr_data, c_dd);
        chk("dw_ack", {31'b0, dw_ack}, {31'b0, c_wa});
        chk("err", {31'b0, err}, {31'b0, c_er});
        rq = {dw_we, dr_re, instr_re};
        if (reset) begin
            g = -1; last = 2; waited = 0;
            e_re = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
        end else if (g >= 0) begin
            if (fin) begin last = g; g = -1; e_re = 0; e_we = 0; end
            else waited++;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (last + k) % 3;
                if (g < 0 && rq[idx]) begin
                    g = idx; waited = 0;
                    e_re = (idx != 2); e_we = (idx == 2);
                    case (idx)
                        0: begin e_sel = instr_sel; e_addr = instr_addr; e_wdata = 0; end
                        1: begin e_sel = dr_sel; e_addr = dr_addr; e_wdata = 0; end
                        default: begin e_sel = dw_sel; e_addr = dw_addr; e_wdata = dw_data; end
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
        chk("mem_re", {31'b0, mem_re}, {31'b0, e_re});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        chk("mem_sel", {28'b0, mem_sel}, {28'b0, e_sel});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        if ((mem_re || mem_we) && !prev_strobe) grants.push_back(mem_addr);
        prev_strobe = mem_re || mem_we;
    endtask

    initial begin
        reset = 1; mem_ack = 0; mem_rdata = 0;
        instr_re = 0; instr_sel = 0; instr_addr = 0;
        dr_re = 0; dr_sel = 0; dr_addr = 0;
        dw_we = 0; dw_sel = 0; dw_addr = 0; dw_data = 0;
        #1;
        cycle(); cycle();
        chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 0;

        // Single instruction fetch, ack two cycles after mem_re rises
        instr_re = 1; instr_addr = 32'h100; instr_sel = 4'hF;
        cycle();
        chk("fetch_re", {31'b0, mem_re}, 32'h1);
        cycle();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        cycle();
        chk("fetch_ack", {31'b0, o_iack}, 32'h1);
        chk("fetch_data", o_idata, 32'hDEADBEEF);
        chk("fetch_re_low", {31'b0, mem_re}, 32'h0);
        instr_re = 0;

        // Spurious ack while idle
        cycle();
        chk("spur_acks", {29'b0, o_iack, o_drack, o_dwack}, 32'h0);
        chk("spur_idle", {30'b0, mem_re, mem_we}, 32'h0);
        mem_ack = 0;

        // Data write
        dw_we = 1; dw_addr = 32'h200; dw_data = 32'h12345678; dw_sel = 4'h3;
        cycle();
        chk("wr_we", {30'b0, mem_we, mem_re}, 32'h2);
        chk("wr_addr", mem_addr, 32'h200);
        chk("wr_data", mem_wdata, 32'h12345678);
        mem_ack = 1;
        cycle();
        chk("wr_ack", {31'b0, o_dwack}, 32'h1);
        dw_we = 0;

        // All three held, ack always high: I, DR, DW, I
        grants.delete();
        instr_re = 1; instr_addr = 32'h10; dr_re = 1; dr_addr = 32'h20;
        dw_we = 1; dw_addr = 32'h30; dw_data = 32'h55;
        for (int i = 0; i < 8; i++) cycle();
        chk("rr_count", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            chk("rr_0", grants[0], 32'h10);
            chk("rr_1", grants[1], 32'h20);
            chk("rr_2", grants[2], 32'h30);
            chk("rr_3", grants[3], 32'h10);
        end
        instr_re = 0; dr_re = 0; dw_we = 0; mem_ack = 0;
        cycle();

        // Timeout on a data read
        n_err = 0; o_drack = 0;
        dr_re = 1; dr_addr = 32'h40; mem_rdata = 32'hFFFF0000;
        for (int i = 0; i < 20 && !o_drack; i++) cycle();
        chk("tmo_ack", {31'b0, o_drack}, 32'h1);
        chk("tmo_data", o_drdata, 32'h0);
        chk("tmo_err", {31'b0, o_err}, 32'h1);
        chk("tmo_idle", {31'b0, mem_re}, 32'h0);
        dr_re = 0;
        cycle(); cycle();
        chk("tmo_err_once", n_err, 32'd1);

        // Reset while a write is outstanding
        dw_we = 1; dw_addr = 32'h300;
        cycle(); cycle();
        reset = 1; mem_ack = 1;
        cycle();
        chk("rst_no_ack", {31'b0, o_dwack}, 32'h0);
        chk("rst_we_low", {31'b0, mem_we}, 32'h0);
        reset = 0; dw_we = 0; mem_ack = 0;
        instr_re = 1; instr_addr = 32'h10; dr_re = 1; dr_addr = 32'h20;
        cycle();
        chk("rst_i_first", mem_addr, 32'h10);
        mem_ack = 1;
        cycle();
        instr_re = 0;
        cycle(); cycle();
        dr_re = 0; mem_ack = 0;

        // Randomized traffic; the granted requester holds its request until acked
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            instr_re = (g == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            dr_re    = (g == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
            dw_we    = (g == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            instr_sel = 4'($urandom); dr_sel = 4'($urandom); dw_sel = 4'($urandom);
            instr_addr = $urandom; dr_addr = $urandom; dw_addr = $urandom;
            dw_data = $urandom; mem_rdata = $urandom;
            mem_ack = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
